// File: rtl/reg_port_arbiter_4way.sv
// Round-robin owner selection for the shared register-file write port; drives the 4-way mux select.
// Optional burst limiting is compiled in with `define ARB_BURST_LIMIT_EN (preempts an owner after MAX_BURST cycles).
module reg_port_arbiter_4way #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         sel,
  output logic               port_valid,
  output logic               owner_changed
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  if (NUM_REQ != 4) begin : g_bad_num_req
    $error("reg_port_arbiter_4way supports NUM_REQ == 4 only");
  end
  if ((MAX_BURST < 1) || (MAX_BURST > 15)) begin : g_bad_max_burst
    $error("reg_port_arbiter_4way needs MAX_BURST in 1..15");
  end

  // First set bit at or after last+1, wrapping; returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = last + 2'(k + 1);
      if (r[idx]) begin
        rr_pick = {1'b1, idx};
      end
    end
  endfunction

  state_t             state_r, state_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_s;
  logic [1:0]         sel_r, sel_s;
  logic               pv_r, pv_s;
  logic               oc_r, oc_s;
  logic [1:0]         last_owner_r, last_owner_s;
  logic               new_grant_s;
  logic [NUM_REQ-1:0] others_s;
  logic [2:0]         pick_all_s, pick_oth_s;
  logic               force_s;

  assign others_s   = req & ~(NUM_REQ'(1) << sel_r);
  assign pick_all_s = rr_pick(req, last_owner_r);
  assign pick_oth_s = rr_pick(others_s, last_owner_r);

`ifdef ARB_BURST_LIMIT_EN
  logic [3:0] burst_r, burst_s;

  // Preempt only when the tenure is used up and somebody else is actually waiting.
  assign force_s = (state_r == GRANT) && (burst_r == 4'(MAX_BURST - 1)) && (|others_s);

  // Owner-cycle counter: cleared on each new grant, wraps while the owner keeps the port.
  always_comb begin
    burst_s = 4'd0;
    if (new_grant_s) begin
      burst_s = 4'd0;
    end else if (state_s == GRANT) begin
      burst_s = (burst_r == 4'(MAX_BURST - 1)) ? 4'd0 : burst_r + 4'd1;
    end else begin
      burst_s = 4'd0;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_r <= 4'd0;
    end else begin
      burst_r <= burst_s;
    end
  end
`else
  assign force_s = 1'b0;
`endif

  // Next owner decision; in GRANT, last_owner_r equals the current owner held in sel_r.
  always_comb begin
    state_s      = state_r;
    gnt_s        = gnt_r;
    sel_s        = sel_r;
    pv_s         = pv_r;
    oc_s         = 1'b0;
    last_owner_s = last_owner_r;
    new_grant_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_all_s[2]) begin
          state_s      = GRANT;
          gnt_s        = NUM_REQ'(1) << pick_all_s[1:0];
          sel_s        = pick_all_s[1:0];
          pv_s         = 1'b1;
          oc_s         = 1'b1;
          last_owner_s = pick_all_s[1:0];
          new_grant_s  = 1'b1;
        end else begin
          gnt_s = '0;
          pv_s  = 1'b0;
        end
      end
      GRANT: begin
        if (req[sel_r] && !force_s) begin
          pv_s = 1'b1;
        end else if (pick_oth_s[2]) begin
          gnt_s        = NUM_REQ'(1) << pick_oth_s[1:0];
          sel_s        = pick_oth_s[1:0];
          pv_s         = 1'b1;
          oc_s         = 1'b1;
          last_owner_s = pick_oth_s[1:0];
          new_grant_s  = 1'b1;
        end else if (req[sel_r]) begin
          pv_s = 1'b1;
        end else begin
          state_s = IDLE;
          gnt_s   = '0;
          pv_s    = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
        pv_s    = 1'b0;
      end
    endcase
  end

  // Output and ownership registers; last_owner resets to 3 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      gnt_r        <= '0;
      sel_r        <= 2'b00;
      pv_r         <= 1'b0;
      oc_r         <= 1'b0;
      last_owner_r <= 2'd3;
    end else begin
      state_r      <= state_s;
      gnt_r        <= gnt_s;
      sel_r        <= sel_s;
      pv_r         <= pv_s;
      oc_r         <= oc_s;
      last_owner_r <= last_owner_s;
    end
  end

  assign gnt           = gnt_r;
  assign sel           = sel_r;
  assign port_valid    = pv_r;
  assign owner_changed = oc_r;

endmodule

// File: tb/tb_reg_port_arbiter_4way.sv
// Scoreboard bench for reg_port_arbiter_4way: directed vectors with hand-computed
// expectations queued by the driver, plus a random phase checked against invariants.
module tb_reg_port_arbiter_4way;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       port_valid;
  logic       owner_changed;

  int checks = 0;
  int errors = 0;
  int step_id = 0;
  logic rand_mode = 1'b0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       pv;
    logic       oc;
    int         id;
  } exp_t;

  exp_t sb[$];

  reg_port_arbiter_4way #(.NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .gnt(gnt),
    .sel(sel),
    .port_valid(port_valid),
    .owner_changed(owner_changed)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] s, input logic pv, input logic oc);
    exp_t e;
    @(negedge clk);
    reset = rst;
    req   = r;
    e.gnt = g;
    e.sel = s;
    e.pv  = pv;
    e.oc  = oc;
    e.id  = step_id;
    step_id++;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard after each edge; in random mode checks invariants instead.
  initial begin
    exp_t       e;
    logic [3:0] req_e;
    logic       rst_e;
    int         wt [4];
    for (int i = 0; i < 4; i++) wt[i] = 0;
    forever begin
      @(posedge clk);
      req_e = req;
      rst_e = reset;
      assert (!$isunknown(req)) else $error("req carries X/Z");
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({gnt, sel, port_valid, owner_changed} !== {e.gnt, e.sel, e.pv, e.oc}) begin
          errors++;
          $display("FAIL step%0d gnt/sel/pv/oc got %b/%b/%b/%b exp %b/%b/%b/%b",
                   e.id, gnt, sel, port_valid, owner_changed, e.gnt, e.sel, e.pv, e.oc);
        end
      end
      if (rand_mode && !rst_e) begin
        checks++;
        if ((gnt & (gnt - 4'd1)) !== 4'b0000) begin
          errors++;
          $display("FAIL onehot gnt=%b", gnt);
        end
        checks++;
        if (gnt[sel] !== port_valid || port_valid !== (|gnt)) begin
          errors++;
          $display("FAIL gnt_sel_pv gnt=%b sel=%0d pv=%b", gnt, sel, port_valid);
        end
        checks++;
        if ((gnt & ~req_e) !== 4'b0000) begin
          errors++;
          $display("FAIL grant_without_req gnt=%b req=%b", gnt, req_e);
        end
        for (int i = 0; i < 4; i++) begin
          if (!req_e[i] || gnt[i]) wt[i] = 0;
          else if (owner_changed) wt[i] = wt[i] + 1;
          checks++;
          if (wt[i] > 3) begin
            errors++;
            $display("FAIL starvation req%0d waited %0d tenures (max 3)", i, wt[i]);
          end
        end
      end else begin
        for (int i = 0; i < 4; i++) wt[i] = 0;
      end
    end
  end

  // Directed stimulus, random phase, then summary.
  initial begin
    // Reset state
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // 1: req 0101, requester 0 first, then direct handover to 2
    step(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    // 2: all request, each owner drops one cycle after two cycles of grant
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b1);
    step(1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // 3: single req[3] pulse of 3 cycles, then idle keeping sel=3
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
    // 4: reset mid-grant, requester 0 first afterwards
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // 5: two requesters held constant, then a lone requester held
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`ifdef ARB_BURST_LIMIT_EN
    for (int k = 0; k < 16; k++) begin
      if (((k / 4) % 2) == 0)
        step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, ((k % 4) == 0) ? 1'b1 : 1'b0);
      else
        step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, ((k % 4) == 0) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 10; k++)
      step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, (k == 0) ? 1'b1 : 1'b0);
`else
    for (int k = 0; k < 8; k++)
      step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, (k == 0) ? 1'b1 : 1'b0);
    for (int k = 0; k < 6; k++)
      step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, (k == 0) ? 1'b1 : 1'b0);
`endif
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    // 6: random requests, invariants checked by the monitor
    @(negedge clk);
    rand_mode = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      req = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    rand_mode = 1'b0;
    req = 4'b0000;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_port_arbiter_4way.md
Name: reg_port_arbiter_4way

Overview:
- Round-robin arbiter/sequencer that shares one register-file write port between four requesters, e.g. ALU writeback, load unit, I/O space write and stack/pointer update.
- Drives the 2-bit select of the existing parameterised 4-way multi-bit multiplexer. S=00 selects requester 0, 01 selects 1, 10 selects 2, 11 selects 3.
- Issues registered one-hot grants plus a port-valid strobe, so the write port sees exactly one owner per cycle.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4, and values other than 4 are unsupported.
- MAX_BURST, 4, maximum consecutive grant cycles per owner while others wait. Range 1..15. Used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i belongs to requester i; level-sensitive.
- gnt  output  4  one-hot grant, registered; all zeros when idle.
- sel  output  2  mux select, registered; binary index of the current or last owner.
- port_valid  output  1  high when the write port has an owner (equals |gnt).
- owner_changed  output  1  one-cycle pulse in the first cycle of each new grant.

Behaviour:
- Reset values:
  - All outputs are sampled at the rising clk edge with reset=1.
  - gnt=0000, sel=00, port_valid=0, owner_changed=0.
  - Internal last_owner=3, so that requester 0 has first priority after reset.
  - Burst counter=0; state=IDLE.
  - Reset is honoured mid-grant: the grant drops the cycle after reset is sampled, and no handover happens.
- States:
  - IDLE: no grant.
  - GRANT: one owner, whose index is held in sel.
- Priority search:
  - Starts at (last_owner+1) mod 4 and wraps through the four indices in ascending order.
  - The first requester found with req set wins.
- IDLE -> GRANT:
  - Any req bit set at edge N gives gnt, port_valid and owner_changed at edge N+1.
  - Latency is 1 cycle.
- GRANT, owner's req still 1:
  - The owner keeps its grant.
  - No preemption without the optional feature.
- GRANT, owner's req 0:
  - If any other req is set, hand over directly to the next round-robin winner in the following cycle, with no idle bubble; owner_changed pulses.
  - If no req is set, go to IDLE: gnt=0000, port_valid=0.
  - sel keeps the last owner's value in IDLE; it is don't-care downstream.
- last_owner updates on every grant.
- A requester that drops and re-raises req while another requester is waiting loses its turn, per round-robin.
- Simultaneous requests: all four set from IDLE after reset means requester 0 wins first. Rotation then gives 1, 2, 3, 0 as each owner releases.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt[sel]==port_valid.
  - A requester is never granted when its req was 0 at the deciding edge.
- Requests with X or Z values are a protocol violation. The bench asserts against them.

Optional Feature:
- Macro: ARB_BURST_LIMIT_EN.
- Enabled:
  - A 4-bit counter counts owner cycles, reset to 0 on each new grant.
  - When count==MAX_BURST-1 and any other req bit is set, the next edge forces a handover even if the owner still requests.
  - If no other requester is waiting, the owner keeps its grant and the counter wraps to 0.
- Disabled:
  - No counter logic exists.
  - The owner holds the grant indefinitely while its req is high.

Test Plan:
1. Reset then req=0101 held: the cycle after the request gives gnt=0001, sel=00, owner_changed=1. Drop req[0] → next cycle gnt=0100, sel=10, no idle cycle.
2. req=1111 held; each owner drops for 1 cycle after 2 cycles of grant: the grant sequence is 0,1,2,3,0 and gnt is never 0000 between grants.
3. Single req[3] pulse lasting 3 cycles: gnt=1000 for 3 cycles starting 1 cycle after assertion, then IDLE with gnt=0000, port_valid=0, sel=11.
4. Reset asserted while gnt=0010 and req=1111: next cycle all outputs equal reset values. After release, requester 0 is granted first.
5. ARB_BURST_LIMIT_EN with MAX_BURST=4, req=0011 held constant: gnt alternates 0001 for 4 cycles, then 0010 for 4 cycles, and so on. With only req[2] held, gnt=0100 continuously.
6. Random req over 10k cycles, checking the invariants: one-hot gnt, gnt[sel]==port_valid, no grant without req, and no requester waiting more than 3 grant tenures (bounded by MAX_BURST when the feature is enabled).
